lcd_timing_regs: RTL and testbench

Bus responder for the LCD timing and status registers FF40–FF45: LCDC, STAT, SCY, SCX, LY and LYC. It sits on the CPU's external address/data bus beside the flash, blockram and sound-register tristates, and replaces the free-running LY stub. It generates Game Boy line/frame timing on the CPU clock and raises VBLANK and STAT interrupt request pulses for the IF logic.

---
 rtl/lcd_timing_regs.sv | 170 +++++++++++++++++
 tb/tb_lcd_timing_regs.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_timing_regs.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : lcd_timing_regs                                                  |
// | Brief   : LCD timing/status registers FF40-FF45 with line/frame timing,    |
// |           mode decode and VBLANK/STAT interrupt request pulses.            |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module lcd_timing_regs #(
    parameter int DOTS_PER_LINE   = 456,
    parameter int LINES_PER_FRAME = 154,
    parameter int VISIBLE_LINES   = 144,
    parameter int OAM_DOTS        = 80,
    parameter int XFER_DOTS       = 172
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] addr_ext,
    input  logic [7:0]  data_in,
    input  logic        mem_we,
    input  logic        mem_re,
    output logic [7:0]  data_out,
    output logic        data_oe,
    output logic [7:0]  scy,
    output logic [7:0]  scx,
    output logic [7:0]  lcdc,
    output logic [7:0]  ly,
    output logic [1:0]  mode,
    output logic        vblank_irq,
    output logic        stat_irq
);

    localparam int DOT_W = $clog2(DOTS_PER_LINE);

    localparam logic [DOT_W-1:0] c_DOT_LAST = DOT_W'(DOTS_PER_LINE - 1);
    localparam logic [DOT_W-1:0] c_OAM_END  = DOT_W'(OAM_DOTS);
    localparam logic [DOT_W-1:0] c_XFER_END = DOT_W'(OAM_DOTS + XFER_DOTS);
    localparam logic [7:0]       c_LY_LAST  = 8'(LINES_PER_FRAME - 1);
    localparam logic [7:0]       c_VBL_LINE = 8'(VISIBLE_LINES);
    localparam logic [7:0]       c_LCDC_RST = 8'h91;

    localparam logic [1:0] c_MODE_HBLANK = 2'd0;
    localparam logic [1:0] c_MODE_VBLANK = 2'd1;
    localparam logic [1:0] c_MODE_OAM    = 2'd2;
    localparam logic [1:0] c_MODE_XFER   = 2'd3;

    logic [DOT_W-1:0] dot_q, dot_d;
    logic [7:0]       ly_q, ly_d;
    logic [1:0]       mode_q, mode_d;
    logic [7:0]       lcdc_q, lcdc_d;
    logic [3:0]       stat_q, stat_d;
    logic [7:0]       scy_q, scy_d;
    logic [7:0]       scx_q, scx_d;
    logic [7:0]       lyc_q, lyc_d;
    logic             stat_line_prev_q;

    logic w_sel;
    logic w_wr;
    logic w_coinc;
    logic w_stat_line;

    assign w_sel = (addr_ext[15:3] == 13'h1FE8) && (addr_ext[2:0] <= 3'd5);
    assign w_wr  = w_sel & mem_we;

    always_comb begin
        lcdc_d = lcdc_q;
        stat_d = stat_q;
        scy_d  = scy_q;
        scx_d  = scx_q;
        lyc_d  = lyc_q;
        if (w_wr) begin
            case (addr_ext[2:0])
                3'd0:    lcdc_d = data_in;
                3'd1:    stat_d = data_in[6:3];
                3'd2:    scy_d  = data_in;
                3'd3:    scx_d  = data_in;
                3'd5:    lyc_d  = data_in;
                default: ;
            endcase
        end
    end

    // Timing holds at line 0/dot 0 while disabled and in the cycle it is re-enabled.
    always_comb begin
        dot_d = dot_q;
        ly_d  = ly_q;
        if (!lcdc_d[7] || !lcdc_q[7]) begin
            dot_d = '0;
            ly_d  = '0;
        end else if (dot_q == c_DOT_LAST) begin
            dot_d = '0;
            ly_d  = (ly_q == c_LY_LAST) ? 8'd0 : ly_q + 8'd1;
        end else begin
            dot_d = dot_q + DOT_W'(1);
        end
    end

    always_comb begin
        if (!lcdc_d[7]) begin
            mode_d = c_MODE_HBLANK;
        end else if (ly_d >= c_VBL_LINE) begin
            mode_d = c_MODE_VBLANK;
        end else if (dot_d < c_OAM_END) begin
            mode_d = c_MODE_OAM;
        end else if (dot_d < c_XFER_END) begin
            mode_d = c_MODE_XFER;
        end else begin
            mode_d = c_MODE_HBLANK;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dot_q            <= '0;
            ly_q             <= '0;
            mode_q           <= c_MODE_OAM;
            lcdc_q           <= c_LCDC_RST;
            stat_q           <= '0;
            scy_q            <= '0;
            scx_q            <= '0;
            lyc_q            <= '0;
            stat_line_prev_q <= 1'b0;
        end else begin
            dot_q            <= dot_d;
            ly_q             <= ly_d;
            mode_q           <= mode_d;
            lcdc_q           <= lcdc_d;
            stat_q           <= stat_d;
            scy_q            <= scy_d;
            scx_q            <= scx_d;
            lyc_q            <= lyc_d;
            stat_line_prev_q <= w_stat_line;
        end
    end

    // Interrupt sources work off registered state, so LYC/STAT writes are seen the cycle after.
    assign w_coinc     = (ly_q == lyc_q);
    assign w_stat_line = lcdc_q[7] & ((stat_q[3] & w_coinc)
                                    | (stat_q[2] & (mode_q == c_MODE_OAM))
                                    | (stat_q[1] & (mode_q == c_MODE_VBLANK))
                                    | (stat_q[0] & (mode_q == c_MODE_HBLANK)));

    assign stat_irq   = w_stat_line & ~stat_line_prev_q;
    assign vblank_irq = lcdc_q[7] & (ly_q == c_VBL_LINE) & (dot_q == '0);

    always_comb begin
        data_out = 8'h00;
        if (w_sel) begin
            case (addr_ext[2:0])
                3'd0:    data_out = lcdc_q;
                3'd1:    data_out = {1'b1, stat_q, w_coinc, mode_q};
                3'd2:    data_out = scy_q;
                3'd3:    data_out = scx_q;
                3'd4:    data_out = ly_q;
                3'd5:    data_out = lyc_q;
                default: data_out = 8'h00;
            endcase
        end
    end

    assign data_oe = w_sel & mem_re & ~mem_we;

    assign scy  = scy_q;
    assign scx  = scx_q;
    assign lcdc = lcdc_q;
    assign ly   = ly_q;
    assign mode = mode_q;

endmodule
`default_nettype wire

// File: tb/tb_lcd_timing_regs.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_lcd_timing_regs                                               |
// | Brief   : Scoreboard bench for lcd_timing_regs: directed bus and timing.   |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_lcd_timing_regs;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] addr_ext;
    logic [7:0]  data_in;
    logic        mem_we;
    logic        mem_re;
    logic [7:0]  data_out;
    logic        data_oe;
    logic [7:0]  scy, scx, lcdc, ly;
    logic [1:0]  mode;
    logic        vblank_irq;
    logic        stat_irq;

    always #5 clock = ~clock;

    lcd_timing_regs dut (
        .clock      (clock),
        .reset      (reset),
        .addr_ext   (addr_ext),
        .data_in    (data_in),
        .mem_we     (mem_we),
        .mem_re     (mem_re),
        .data_out   (data_out),
        .data_oe    (data_oe),
        .scy        (scy),
        .scx        (scx),
        .lcdc       (lcdc),
        .ly         (ly),
        .mode       (mode),
        .vblank_irq (vblank_irq),
        .stat_irq   (stat_irq)
    );

    typedef struct {
        string      name;
        logic       oe;
        logic [7:0] data;
    } rd_exp_t;

    typedef struct {
        string      name;
        logic [7:0] ly;
        logic [1:0] mode;
        logic [7:0] lcdc;
        logic [7:0] scy;
        logic [7:0] scx;
    } st_exp_t;

    rd_exp_t rd_q[$];
    st_exp_t st_q[$];
    int      vbl_q[$];
    int      irq_q[$];

    int         cyc;
    logic       probe;
    logic       done;
    logic [7:0] exp_scy;
    logic [7:0] exp_scx;
    int         checks;
    int         errors;

    // cyc = number of enabled clocks since reset release (dot counter while LCD runs)
    always @(posedge clock) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) tick();
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        addr_ext = a;
        data_in  = d;
        mem_we   = 1'b1;
        tick();
        mem_we   = 1'b0;
        addr_ext = 16'h0000;
        data_in  = 8'h00;
    endtask

    task automatic rd(input string nm, input logic [15:0] a, input logic oe, input logic [7:0] d);
        rd_exp_t e;
        e.name = nm; e.oe = oe; e.data = d;
        rd_q.push_back(e);
        addr_ext = a;
        mem_re   = 1'b1;
        tick();
        mem_re   = 1'b0;
        addr_ext = 16'h0000;
    endtask

    task automatic chk(input string nm, input logic [7:0] l, input logic [1:0] m, input logic [7:0] c);
        st_exp_t e;
        e.name = nm; e.ly = l; e.mode = m; e.lcdc = c; e.scy = exp_scy; e.scx = exp_scx;
        st_q.push_back(e);
        probe = 1'b1;
        tick();
        probe = 1'b0;
    endtask

    // Monitor: pops expectations whenever the DUT presents read data, a probe, or an irq pulse.
    initial begin
        rd_exp_t re;
        st_exp_t se;
        int      t;
        int      edges;
        checks = 0;
        errors = 0;
        edges  = 0;
        forever begin
            @(negedge clock);
            edges++;
            if (mem_re) begin
                checks++;
                if (rd_q.size() == 0) begin
                    errors++;
                    $display("FAIL rd_unexpected: oe=%b data=%02h, no read expected", data_oe, data_out);
                end else begin
                    re = rd_q.pop_front();
                    if (data_oe !== re.oe || data_out !== re.data) begin
                        errors++;
                        $display("FAIL %s: oe=%b data=%02h, expected oe=%b data=%02h",
                                 re.name, data_oe, data_out, re.oe, re.data);
                    end
                end
            end else if (data_oe !== 1'b0) begin
                checks++;
                errors++;
                $display("FAIL data_oe_idle: oe=%b, expected 0 with no read", data_oe);
            end
            if (probe) begin
                checks++;
                if (st_q.size() == 0) begin
                    errors++;
                    $display("FAIL probe_unexpected: no state expectation queued");
                end else begin
                    se = st_q.pop_front();
                    if (ly !== se.ly || mode !== se.mode || lcdc !== se.lcdc ||
                        scy !== se.scy || scx !== se.scx) begin
                        errors++;
                        $display("FAIL %s @%0d: ly=%0d mode=%0d lcdc=%02h scy=%02h scx=%02h, expected ly=%0d mode=%0d lcdc=%02h scy=%02h scx=%02h",
                                 se.name, cyc, ly, mode, lcdc, scy, scx,
                                 se.ly, se.mode, se.lcdc, se.scy, se.scx);
                    end
                end
            end
            if (reset && vbl_q.size() > 0 && vbl_q[0] == cyc) begin
                t = vbl_q.pop_front();
                checks++;
                if (vblank_irq !== 1'b1) begin
                    errors++;
                    $display("FAIL vblank_missing @%0d: vblank_irq=%b, expected 1", t, vblank_irq);
                end
            end else if (vblank_irq !== 1'b0) begin
                checks++;
                errors++;
                $display("FAIL vblank_unexpected @%0d: vblank_irq=%b, expected 0", cyc, vblank_irq);
            end
            if (reset && irq_q.size() > 0 && irq_q[0] == cyc) begin
                t = irq_q.pop_front();
                checks++;
                if (stat_irq !== 1'b1) begin
                    errors++;
                    $display("FAIL stat_missing @%0d: stat_irq=%b, expected 1", t, stat_irq);
                end
            end else if (stat_irq !== 1'b0) begin
                checks++;
                errors++;
                $display("FAIL stat_unexpected @%0d: stat_irq=%b, expected 0", cyc, stat_irq);
            end
            if (edges > 95000) begin
                checks++;
                errors++;
                $display("FAIL timeout: %0d clocks elapsed, expected end before 95000", edges);
            end
            if (done || edges > 95000) begin
                while (rd_q.size() > 0) begin
                    re = rd_q.pop_front(); checks++; errors++;
                    $display("FAIL %s: read never observed, expected %02h", re.name, re.data);
                end
                while (st_q.size() > 0) begin
                    se = st_q.pop_front(); checks++; errors++;
                    $display("FAIL %s: probe never observed, expected ly=%0d", se.name, se.ly);
                end
                while (vbl_q.size() > 0) begin
                    t = vbl_q.pop_front(); checks++; errors++;
                    $display("FAIL vblank_pending: pulse at %0d not seen, expected 1", t);
                end
                while (irq_q.size() > 0) begin
                    t = irq_q.pop_front(); checks++; errors++;
                    $display("FAIL stat_pending: pulse at %0d not seen, expected 1", t);
                end
                $display("CHECKS %0d ERRORS %0d", checks, errors);
                $finish;
            end
        end
    end

    localparam logic [15:0] A_LCDC = 16'hFF40;
    localparam logic [15:0] A_STAT = 16'hFF41;
    localparam logic [15:0] A_SCY  = 16'hFF42;
    localparam logic [15:0] A_SCX  = 16'hFF43;
    localparam logic [15:0] A_LY   = 16'hFF44;
    localparam logic [15:0] A_LYC  = 16'hFF45;
    localparam int          R      = 71372;   // cycle at which timing restarts after re-enable

    initial begin
        reset    = 1'b0;
        addr_ext = 16'h0000;
        data_in  = 8'h00;
        mem_we   = 1'b0;
        mem_re   = 1'b0;
        probe    = 1'b0;
        done     = 1'b0;
        exp_scy  = 8'h00;
        exp_scx  = 8'h00;
        repeat (3) tick();
        chk("hold_reset", 8'd0, 2'd2, 8'h91);
        reset = 1'b1;

        // Reset state; LY==LYC==0 so the coincidence flag reads set in FF41.
        chk("reset_state", 8'd0, 2'd2, 8'h91);
        rd("rd_stat_reset", A_STAT, 1'b1, 8'h86);
        rd("rd_ff46", 16'hFF46, 1'b0, 8'h00);
        wr(A_LYC, 8'h05);
        wr(A_STAT, 8'h4F);                       // low bits ignored: STAT = coinc + mode0 enables
        wr(A_SCY, 8'h12);
        wr(A_SCX, 8'h34);
        exp_scy = 8'h12;
        exp_scx = 8'h34;
        rd("rd_scy", A_SCY, 1'b1, 8'h12);
        rd("rd_scx", A_SCX, 1'b1, 8'h34);
        rd("rd_lyc", A_LYC, 1'b1, 8'h05);
        rd("rd_stat_w", A_STAT, 1'b1, 8'hCA);
        rd("rd_lcdc", A_LCDC, 1'b1, 8'h91);
        rd("rd_ly0", A_LY, 1'b1, 8'h00);

        // Mode-0 edge on every visible line; line 5 is skipped because coincidence keeps
        // the line high from the end of line 4 through line 5.
        for (int l = 0; l < 144; l++)
            if (l != 5) irq_q.push_back(l * 456 + 252);
        vbl_q.push_back(65664);

        wait_cyc(79);    chk("dot79",  8'd0,   2'd2, 8'h91);
                         chk("dot80",  8'd0,   2'd3, 8'h91);
        wait_cyc(251);   chk("dot251", 8'd0,   2'd3, 8'h91);
                         chk("dot252", 8'd0,   2'd0, 8'h91);
        wait_cyc(455);   chk("dot455", 8'd0,   2'd0, 8'h91);
                         chk("line1",  8'd1,   2'd2, 8'h91);
        wait_cyc(65663); chk("ly143_end", 8'd143, 2'd0, 8'h91);
                         chk("ly144",  8'd144, 2'd1, 8'h91);
        rd("rd_ly144", A_LY, 1'b1, 8'h90);
        rd("rd_stat_vbl", A_STAT, 1'b1, 8'hC9);
        wait_cyc(70223); chk("ly153_end", 8'd153, 2'd1, 8'h91);
                         chk("frame_wrap", 8'd0, 2'd2, 8'h91);
        irq_q.push_back(70224 + 252);
        irq_q.push_back(70224 + 456 + 252);

        // Disable mid-line, LY write ignored, re-enable restarts the frame.
        wait_cyc(71362);
        wr(A_LY, 8'h33);
        chk("ly_wr_ignored", 8'd2, 2'd3, 8'h91);
        wr(A_LCDC, 8'h11);
        chk("disabled", 8'd0, 2'd0, 8'h11);
        rd("rd_ly_off", A_LY, 1'b1, 8'h00);
        wait_cyc(71370); chk("still_off", 8'd0, 2'd0, 8'h11);
        wr(A_LCDC, 8'h91);
        chk("restart", 8'd0, 2'd2, 8'h91);
        wr(A_STAT, 8'h20);                       // mode-2 enable while in mode 2: immediate edge
        irq_q.push_back(R + 2);
        wait_cyc(R + 80);  chk("restart_dot80", 8'd0, 2'd3, 8'h91);
        wait_cyc(R + 100);
        wr(A_STAT, 8'h40);
        irq_q.push_back(R + 2280);               // LY reaches LYC=5
        irq_q.push_back(R + 2801);               // LYC rewritten to current LY=6
        wait_cyc(R + 2279); chk("ly4_end", 8'd4, 2'd0, 8'h91);
                            chk("ly5",     8'd5, 2'd2, 8'h91);
        wait_cyc(R + 2800);
        wr(A_LYC, 8'h06);
        rd("rd_stat_coinc", A_STAT, 1'b1, 8'hC6);
        rd("rd_lyc6", A_LYC, 1'b1, 8'h06);

        // Asynchronous reset mid-frame.
        wait_cyc(R + 2808);
        reset   = 1'b0;
        exp_scy = 8'h00;
        exp_scx = 8'h00;
        chk("mid_reset", 8'd0, 2'd2, 8'h91);
        rd("rd_stat_rst", A_STAT, 1'b1, 8'h86);
        rd("rd_lyc_rst", A_LYC, 1'b1, 8'h00);
        rd("rd_scy_rst", A_SCY, 1'b1, 8'h00);
        reset = 1'b1;
        repeat (3) tick();
        done = 1'b1;
    end

endmodule
`default_nettype wire
